// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, width limit and
// the counter-width helper used by the sequencer.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MAX_WIDTH = 32;

    // Bit counter never needs fewer than one bit, even for WIDTH=1.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell made of two half adders and an OR gate;
// the carry is held outside this cell by the sequencer.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = a ^ b;
    assign hc1 = a & b;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes a bit pair
// per clock, LSB first, with the carry held in a flop between positions.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] sum_shift;
    logic             last_bit;

    serial_fa_cell u_cell (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_c)
    );

    // New sum bit enters at the MSB so the LSB computed first ends up at bit 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift = cell_s;
        end else begin : g_shift_wn
            assign sum_shift = {cell_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                sum_d   = sum_shift;
                carry_d = cell_c;
                if (last_bit) begin
                    // Hold the counter on the final bit so it never wraps.
                    cout_d  = cell_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for the serial adder: WIDTH=4 and WIDTH=1 instances,
// expectations queued at capture and compared when done rises.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int res;
        int due;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {cout,sum} reference for a w-bit operation.
    function automatic int golden(input int w, input int aa, input int bb, input int s, input int c);
        int mask;
        mask = (1 << w) - 1;
        if (s == 0) return aa + bb + c;
        return ((aa - bb) & mask) | ((aa >= bb ? 1 : 0) << w);
    endfunction

    logic done4_prev = 1'b0;
    logic done1_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done4 && !done4_prev) begin
            if (q4.size() == 0) check_val("unexpected_done4", 1, 0);
            else begin
                e = q4.pop_front();
                check_val("result4", {59'd0, cout4, sum4}, e.res);
                check_val("latency4", cyc, e.due);
            end
        end
        done4_prev <= done4;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) check_val("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                check_val("result1", {62'd0, cout1, sum1}, e.res);
                check_val("latency1", cyc, e.due);
            end
        end
        done1_prev <= done1;
    end

    // Issue one op on the WIDTH=4 instance; returns 1 time unit after the capture edge.
    task automatic op4(input int aa, input int bb, input int s, input int c);
        exp_t e;
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'(aa); b4 = 4'(bb); sub4 = 1'(s); cin4 = 1'(c);
        @(posedge clk); #1;
        e.res = golden(4, aa, bb, s, c);
        e.due = cyc + 4;
        q4.push_back(e);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom); cin4 = 1'($urandom);
    endtask

    task automatic op1(input int aa, input int bb, input int s, input int c);
        exp_t e;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 1'(aa); b1 = 1'(bb); sub1 = 1'(s); cin1 = 1'(c);
        @(posedge clk); #1;
        e.res = golden(1, aa, bb, s, c);
        e.due = cyc + 1;
        q1.push_back(e);
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom);
    endtask

    task automatic wait4();
        int n = 0;
        while (q4.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) begin
            check_val("timeout4", q4.size(), 0);
            q4.delete();
        end
    endtask

    task automatic wait1();
        int n = 0;
        while (q1.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) begin
            check_val("timeout1", q1.size(), 0);
            q1.delete();
        end
    endtask

    initial begin
        exp_t e;
        int na, nb;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy4", busy4, 0);
        check_val("rst_done4", done4, 0);
        check_val("rst_sum4", sum4, 0);
        check_val("rst_cout4", cout4, 0);
        check_val("rst_busy1", busy1, 0);
        check_val("rst_done1", done1, 0);
        rst = 1'b0;

        // 15+1: busy for exactly 4 cycles, then done with {1,0}
        op4(15, 1, 0, 0);
        check_val("t1_busy_e0", busy4, 1);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check_val("t1_busy_run", busy4, 1);
            check_val("t1_done_run", done4, 0);
        end
        @(posedge clk); #1;
        check_val("t1_busy_end", busy4, 0);
        check_val("t1_done_end", done4, 1);
        wait4();

        // Subtraction with and without borrow
        op4(9, 3, 1, 0);
        wait4();
        op4(3, 9, 1, 1);
        wait4();

        // Start pulse during RUN must be ignored
        op4(5, 6, 0, 1);
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait4();

        // Reset in the middle of RUN discards the op
        op4(7, 7, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q4.delete();
        check_val("t4_busy", busy4, 0);
        check_val("t4_done", done4, 0);
        check_val("t4_sum", sum4, 0);
        check_val("t4_cout", cout4, 0);
        @(negedge clk);
        check_val("t4_idle_busy", busy4, 0);
        op4(2, 9, 0, 1);
        wait4();

        // Back-to-back with start held high in DONE
        @(posedge clk); #1;
        na = 11; nb = 4;
        start4 = 1'b1; a4 = 4'(na); b4 = 4'(nb); sub4 = 1'b0; cin4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            e.res = golden(4, na, nb, int'(sub4), int'(cin4));
            e.due = cyc + 4;
            q4.push_back(e);
            na = int'($urandom_range(0, 15));
            nb = int'($urandom_range(0, 15));
            a4 = 4'(na); b4 = 4'(nb); sub4 = 1'(i % 2); cin4 = 1'($urandom);
            check_val("b2b_busy", busy4, 1);
            repeat (4) @(posedge clk);
            #1;
            check_val("b2b_done", done4, 1);
            if (i == 5) start4 = 1'b0;
        end
        wait4();

        // Exhaustive sweep, WIDTH=4
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        op4(x, y, s, c);
                        wait4();
                    end

        // Exhaustive sweep, WIDTH=1
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 2; x++)
                    for (int y = 0; y < 2; y++) begin
                        op1(x, y, s, c);
                        wait1();
                    end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
